// File: rtl/mcyc_ctrl.sv
// Multicycle RV32I control FSM: sequences the shared ALU, memory port and IR/PC registers.
// Optional MCYC_CTRL_PERF_EN adds cycles/instret performance counters.
module mcyc_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       br_taken,
  output logic       pc_we,
  output logic       adr_src,
  output logic       mem_we,
  output logic       ir_we,
  output logic       reg_we,
  output logic [1:0] res_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] imm_src,
  output logic       err,
  output logic [3:0] state
`ifdef MCYC_CTRL_PERF_EN
  ,
  output logic [31:0] cycles,
  output logic [31:0] instret
`endif
);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  EXECR  = 4'd6,  EXECI = 4'd7,
    ALUWB  = 4'd8,  BRANCH = 4'd9,  JAL    = 4'd10, JALR  = 4'd11,
    LUI    = 4'd12, ERR    = 4'd13
  } state_t;

  state_t cur, nxt;
  // Set while ALUWB follows JALR: alu_out holds the jump target there, so the
  // link value old_pc+4 is recomputed in ALUWB and taken from the comb ALU result.
  logic   jalr_wb;

  assign state = cur;

  always_ff @(posedge clk) begin
    if (rst) begin
      cur     <= FETCH;
      jalr_wb <= 1'b0;
    end else begin
      cur     <= nxt;
      jalr_wb <= (cur == JALR);
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = MEMADR;
          OP_R:         nxt = EXECR;
          OP_I:         nxt = EXECI;
          OP_BR:        nxt = BRANCH;
          OP_JAL:       nxt = JAL;
          OP_JALR:      nxt = JALR;
          OP_LUI:       nxt = LUI;
          default:      nxt = ERR;
        endcase
      end
      MEMADR: nxt = (op == OP_LW) ? MEMRD : MEMWR;
      MEMRD:  nxt = MEMWB;
      EXECR, EXECI, JAL, JALR, LUI: nxt = ALUWB;
      MEMWB, MEMWR, ALUWB, BRANCH:  nxt = FETCH;
      ERR:    nxt = ERR;
      default: nxt = FETCH;
    endcase
  end

  always_comb begin
    pc_we     = 1'b0;
    adr_src   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    reg_we    = 1'b0;
    res_src   = 2'd0;
    alu_src_a = 2'd0;
    alu_src_b = 2'd0;
    alu_op    = 2'd0;
    imm_src   = 3'd0;
    err       = 1'b0;
    case (cur)
      FETCH: begin
        ir_we = 1'b1; alu_src_b = 2'd2; res_src = 2'd2; pc_we = 1'b1;
      end
      DECODE: begin
        alu_src_a = 2'd1; alu_src_b = 2'd1; imm_src = 3'd2;
      end
      MEMADR: begin
        alu_src_a = 2'd2; alu_src_b = 2'd1;
        imm_src   = (op == OP_LW) ? 3'd0 : 3'd1;
      end
      MEMRD: adr_src = 1'b1;
      MEMWB: begin
        res_src = 2'd1; reg_we = 1'b1;
      end
      MEMWR: begin
        adr_src = 1'b1; mem_we = 1'b1;
      end
      EXECR: begin
        alu_src_a = 2'd2; alu_op = 2'd2;
      end
      EXECI: begin
        alu_src_a = 2'd2; alu_src_b = 2'd1; alu_op = 2'd2;
      end
      ALUWB: begin
        reg_we = 1'b1;
        if (jalr_wb) begin
          alu_src_a = 2'd1; alu_src_b = 2'd2; res_src = 2'd2;
        end
      end
      BRANCH: begin
        alu_src_a = 2'd2; alu_op = 2'd1; pc_we = br_taken;
      end
      JAL: begin
        alu_src_a = 2'd1; alu_src_b = 2'd2; pc_we = 1'b1;
      end
      JALR: begin
        alu_src_a = 2'd2; alu_src_b = 2'd1; res_src = 2'd2; pc_we = 1'b1;
      end
      LUI: begin
        alu_src_b = 2'd1; imm_src = 3'd4; alu_op = 2'd3;
      end
      ERR: err = 1'b1;
      default: ;
    endcase
    if (rst) begin
      pc_we  = 1'b0;
      ir_we  = 1'b0;
      mem_we = 1'b0;
      reg_we = 1'b0;
    end
  end

`ifdef MCYC_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles  <= 32'd0;
      instret <= 32'd0;
    end else begin
      if (cur != ERR) cycles <= cycles + 32'd1;
      if (nxt == FETCH && cur != FETCH && cur != ERR) instret <= instret + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mcyc_ctrl.sv
// Scoreboard bench for mcyc_ctrl: driver pushes hand-derived expected outputs,
// negedge monitor pops and compares every cycle.
module tb_mcyc_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] op = 7'b0010011;
  logic       br_taken = 1'b0;
  logic       pc_we, adr_src, mem_we, ir_we, reg_we, err;
  logic [1:0] res_src, alu_src_a, alu_src_b, alu_op;
  logic [2:0] imm_src;
  logic [3:0] state;
`ifdef MCYC_CTRL_PERF_EN
  logic [31:0] cycles, instret;
`endif

  mcyc_ctrl dut (
    .clk(clk), .rst(rst), .op(op), .br_taken(br_taken),
    .pc_we(pc_we), .adr_src(adr_src), .mem_we(mem_we), .ir_we(ir_we),
    .reg_we(reg_we), .res_src(res_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_op(alu_op), .imm_src(imm_src),
    .err(err), .state(state)
`ifdef MCYC_CTRL_PERF_EN
    , .cycles(cycles), .instret(instret)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RR = 7'b0110011,
                         ORI = 7'b0010011, BEQ = 7'b1100011, JALO = 7'b1101111,
                         JALRO = 7'b1100111, LUIO = 7'b0110111, BAD = 7'b1111111;
  localparam int S_FETCH = 0, S_DECODE = 1, S_MEMADR = 2, S_MEMRD = 3, S_MEMWB = 4,
                 S_MEMWR = 5, S_EXECR = 6, S_EXECI = 7, S_ALUWB = 8, S_BRANCH = 9,
                 S_JAL = 10, S_JALR = 11, S_LUI = 12, S_ERR = 13, S_ALUWB_JALR = 14;

  typedef struct packed {
    logic [3:0] st;
    logic       pc_we, adr_src, mem_we, ir_we, reg_we;
    logic [1:0] res_src, a, b, aop;
    logic [2:0] imm;
    logic       err;
  } exp_t;

  typedef struct {
    int   idx;
    exp_t e;
  } sb_t;

  sb_t q[$];
  int  checks = 0;
  int  failures = 0;
  int  vec = 0;

  // Expected outputs per state, written out by hand from the state table.
  function automatic exp_t exp_for(input int s, input logic [6:0] o, input bit br, input bit r);
    exp_t e;
    e = '0;
    e.st = 4'(s);
    case (s)
      S_FETCH:  begin e.ir_we = 1; e.b = 2; e.res_src = 2; e.pc_we = 1; end
      S_DECODE: begin e.a = 1; e.b = 1; e.imm = 2; end
      S_MEMADR: begin e.a = 2; e.b = 1; e.imm = (o == LW) ? 3'd0 : 3'd1; end
      S_MEMRD:  begin e.adr_src = 1; end
      S_MEMWB:  begin e.res_src = 1; e.reg_we = 1; end
      S_MEMWR:  begin e.adr_src = 1; e.mem_we = 1; end
      S_EXECR:  begin e.a = 2; e.aop = 2; end
      S_EXECI:  begin e.a = 2; e.b = 1; e.aop = 2; end
      S_ALUWB:  begin e.reg_we = 1; end
      S_BRANCH: begin e.a = 2; e.aop = 1; e.pc_we = br; end
      S_JAL:    begin e.a = 1; e.b = 2; e.pc_we = 1; end
      S_JALR:   begin e.a = 2; e.b = 1; e.res_src = 2; e.pc_we = 1; end
      S_LUI:    begin e.b = 1; e.imm = 4; e.aop = 3; end
      S_ERR:    begin e.err = 1; end
      S_ALUWB_JALR: begin e.st = 4'd8; e.a = 1; e.b = 2; e.res_src = 2; e.reg_we = 1; end
      default: ;
    endcase
    if (r) begin e.pc_we = 0; e.ir_we = 0; e.mem_we = 0; e.reg_we = 0; end
    return e;
  endfunction

  // One clock: drive inputs, push the expectation for this cycle, advance.
  task automatic cyc(input bit r, input logic [6:0] o, input bit br, input int s);
    sb_t t;
    rst = r; op = o; br_taken = br;
    t.idx = vec; t.e = exp_for(s, o, br, r);
    q.push_back(t);
    vec++;
    @(posedge clk); #1;
  endtask

  task automatic instr(input logic [6:0] o, input bit br, input int s2, input int s3, input int s4);
    cyc(0, o, br, S_FETCH);
    cyc(0, o, br, S_DECODE);
    cyc(0, o, br, s2);
    if (s3 >= 0) cyc(0, o, br, s3);
    if (s4 >= 0) cyc(0, o, br, s4);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      sb_t t;
      exp_t act;
      t = q.pop_front();
      act = {state, pc_we, adr_src, mem_we, ir_we, reg_we, res_src,
             alu_src_a, alu_src_b, alu_op, imm_src, err};
      checks++;
      if (act !== t.e) begin
        failures++;
        $display("FAIL vec%0d outputs: got %h expected %h (state got %0d exp %0d)",
                 t.idx, act, t.e, state, t.e.st);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    @(posedge clk); #1;
    cyc(1, ORI, 0, S_FETCH);
    cyc(1, ORI, 0, S_FETCH);
    repeat (3) instr(ORI, 0, S_EXECI, S_ALUWB, -1);
    instr(LW, 0, S_MEMADR, S_MEMRD, S_MEMWB);
`ifdef MCYC_CTRL_PERF_EN
    checks++;
    if (cycles !== 32'd17 || instret !== 32'd4) begin
      failures++;
      $display("FAIL perf_count: got cycles=%0d instret=%0d expected 17/4", cycles, instret);
    end
`endif
    instr(SW, 0, S_MEMADR, S_MEMWR, -1);
    instr(RR, 0, S_EXECR, S_ALUWB, -1);
    instr(BEQ, 1, S_BRANCH, -1, -1);
    instr(BEQ, 0, S_BRANCH, -1, -1);
    instr(JALO, 0, S_JAL, S_ALUWB, -1);
    instr(JALRO, 0, S_JALR, S_ALUWB_JALR, -1);
    instr(LUIO, 0, S_LUI, S_ALUWB, -1);
    cyc(0, BAD, 0, S_FETCH);
    cyc(0, BAD, 0, S_DECODE);
    repeat (10) cyc(0, BAD, 0, S_ERR);
    cyc(1, BAD, 0, S_ERR);
    instr(ORI, 0, S_EXECI, S_ALUWB, -1);
    // Reset while lw sits in MEMWB: writeback must be suppressed and lw abandoned.
    cyc(0, LW, 0, S_FETCH);
    cyc(0, LW, 0, S_DECODE);
    cyc(0, LW, 0, S_MEMADR);
    cyc(0, LW, 0, S_MEMRD);
    cyc(1, LW, 0, S_MEMWB);
`ifdef MCYC_CTRL_PERF_EN
    checks++;
    if (cycles !== 32'd0 || instret !== 32'd0) begin
      failures++;
      $display("FAIL perf_reset: got cycles=%0d instret=%0d expected 0/0", cycles, instret);
    end
`endif
    instr(ORI, 0, S_EXECI, S_ALUWB, -1);
    @(negedge clk); #1;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL sb_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
